// File: rtl/iram_loader.sv
// iram_loader: packs a boot byte stream into 16-bit IRAM words, starts the CPU and times its run.
module iram_loader #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic        iram_we,
  output logic [7:0]  iram_waddr,
  output logic [15:0] iram_wdata,
  output logic        cpu_start,
  input  logic        cpu_idle,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [8:0]  words,
  output logic [15:0] run_cycles
);
  typedef enum logic [2:0] {S_LOAD_LO, S_LOAD_HI, S_DRAIN, S_START, S_RUN_ACK, S_RUN} state_t;
  state_t      r_state, w_state;
  logic [7:0]  r_lo, w_lo;
  logic [8:0]  r_words, w_words;
  logic        r_we, w_we;
  logic [7:0]  r_waddr, w_waddr;
  logic [15:0] r_wdata, w_wdata;
  logic        r_start, w_start;
  logic        r_done, w_done;
  logic        r_err, w_err;
  logic [15:0] r_run, w_run;
  logic [1:0]  r_ack, w_ack;
  logic        w_hs, w_full;
  assign s_ready    = (r_state == S_LOAD_LO) || (r_state == S_LOAD_HI) || (r_state == S_DRAIN);
  assign busy       = !((r_state == S_LOAD_LO) && (r_words == 9'd0));
  assign iram_we    = r_we;
  assign iram_waddr = r_waddr;
  assign iram_wdata = r_wdata;
  assign cpu_start  = r_start;
  assign done       = r_done;
  assign err        = r_err;
  assign words      = r_words;
  assign run_cycles = r_run;
  assign w_hs       = s_valid && s_ready;
  assign w_full     = r_words == 9'(DEPTH);
  always_comb begin
    w_state = r_state;
    w_lo    = r_lo;
    w_words = r_words;
    w_we    = 1'b0;
    w_waddr = r_waddr;
    w_wdata = r_wdata;
    w_start = 1'b0;
    w_done  = 1'b0;
    w_err   = r_err;
    w_run   = r_run;
    w_ack   = r_ack;
    case (r_state)
      S_LOAD_LO: if (w_hs) begin
        if (r_words == 9'd0) w_err = 1'b0;
        w_lo    = s_data;
        w_state = S_LOAD_HI;
        if (s_last) begin
          w_err = 1'b1;
          if (w_full) begin
            w_state = S_LOAD_LO;
            w_words = 9'd0;
          end else begin
            w_we    = 1'b1;
            w_waddr = r_words[7:0];
            w_wdata = {8'h00, s_data};
            w_words = r_words + 9'd1;
            w_state = S_START;
          end
        end
      end
      S_LOAD_HI: if (w_hs) begin
        if (w_full) begin
          w_err   = 1'b1;
          w_state = s_last ? S_LOAD_LO : S_DRAIN;
          w_words = s_last ? 9'd0 : r_words;
        end else begin
          w_we    = 1'b1;
          w_waddr = r_words[7:0];
          w_wdata = {s_data, r_lo};
          w_words = r_words + 9'd1;
          w_state = s_last ? S_START : S_LOAD_LO;
        end
      end
      S_DRAIN: if (w_hs && s_last) begin
        w_state = S_LOAD_LO;
        w_words = 9'd0;
      end
      S_START: if (cpu_idle) begin
        w_start = 1'b1;
        w_run   = 16'd0;
        w_ack   = 2'd0;
        w_state = S_RUN_ACK;
      end
      // the cycle that sees the CPU go busy is already part of the run
      S_RUN_ACK: if (!cpu_idle) begin
        w_run   = 16'd1;
        w_state = S_RUN;
      end else if (r_ack == 2'd3) begin
        w_err   = 1'b1;
        w_done  = 1'b1;
        w_words = 9'd0;
        w_state = S_LOAD_LO;
      end else w_ack = r_ack + 2'd1;
      S_RUN: if (cpu_idle) begin
        w_done  = 1'b1;
        w_words = 9'd0;
        w_state = S_LOAD_LO;
      end else w_run = (r_run == 16'hFFFF) ? r_run : r_run + 16'd1;
      default: w_state = S_LOAD_LO;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD_LO;
      r_lo    <= '0;
      r_words <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_start <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_run   <= '0;
      r_ack   <= '0;
    end else begin
      r_state <= w_state;
      r_lo    <= w_lo;
      r_words <= w_words;
      r_we    <= w_we;
      r_waddr <= w_waddr;
      r_wdata <= w_wdata;
      r_start <= w_start;
      r_done  <= w_done;
      r_err   <= w_err;
      r_run   <= w_run;
      r_ack   <= w_ack;
    end
  end
endmodule

// File: tb/tb_iram_loader.sv
// tb_iram_loader: randomized scoreboard bench for iram_loader with a behavioural CPU model.
module tb_iram_loader;
  localparam int DEPTH = 256;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        cpu_idle = 1'b1;
  logic        s_ready, iram_we, cpu_start, busy, done, err;
  logic [7:0]  iram_waddr;
  logic [15:0] iram_wdata, run_cycles;
  logic [8:0]  words;
  int checks = 0, errors = 0, n_starts = 0, run_len = 0;
  bit hold = 1'b0;
  logic [23:0] wq[$];
  logic [16:0] dq[$];
  logic [7:0]  p[$];

  always #5 clk = ~clk;

  iram_loader #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .iram_we(iram_we), .iram_waddr(iram_waddr), .iram_wdata(iram_wdata),
    .cpu_start(cpu_start), .cpu_idle(cpu_idle), .busy(busy), .done(done), .err(err),
    .words(words), .run_cycles(run_cycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitor: pops expected writes and run results whenever the DUT presents them
  initial forever begin
    @(negedge clk);
    if (iram_we) begin
      if (wq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write actual=%0h expected=none", {iram_waddr, iram_wdata});
      end else chk("iram_write", {8'h00, iram_waddr, iram_wdata}, {8'h00, wq.pop_front()});
    end
    if (done) begin
      if (dq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else chk("done_result", {15'h0, err, run_cycles}, {15'h0, dq.pop_front()});
    end
  end

  // CPU model: goes busy for run_len cycles after each start pulse
  initial forever begin
    @(negedge clk);
    if (cpu_start) begin
      n_starts++;
      chk("start_while_busy", cpu_idle, 1);
      cpu_idle = 1'b0;
      repeat (run_len) @(negedge clk);
      cpu_idle = 1'b1;
    end else cpu_idle = !hold;
  end

  task automatic rst_chk(input string tag);
    chk({tag, "_ctl"}, {iram_we, cpu_start, busy, done, err, words}, 0);
    chk({tag, "_wr"}, {iram_waddr, iram_wdata}, 0);
    chk({tag, "_run"}, run_cycles, 0);
    chk({tag, "_ready"}, s_ready, 1);
  endtask

  task automatic run_prog(input logic [7:0] b[$], input int maxgap, input int rl,
                          input bit hold_cpu, input bit wait_done);
    int n, nw, s0;
    bit ovf;
    n = b.size();
    nw = (n + 1) / 2;
    ovf = nw > DEPTH;
    for (int i = 0; i < nw && i < DEPTH; i++)
      wq.push_back({8'(i), (2 * i + 1 < n) ? b[2 * i + 1] : 8'h00, b[2 * i]});
    if (!ovf) dq.push_back({((n % 2) == 1) || (rl == 0), 16'(rl)});
    run_len = rl;
    hold = hold_cpu;
    s0 = n_starts;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(maxgap, 0)) begin
        @(negedge clk); s_valid = 1'b0; s_last = 1'b0;
      end
      @(negedge clk);
      s_data = b[i]; s_valid = 1'b1; s_last = (i == n - 1);
      if (i == 0 || i >= 2 * DEPTH) chk("s_ready", s_ready, 1);
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
    chk("words_after_load", words, ovf ? 0 : nw);
    chk("err_after_load", err, ((n % 2) == 1) || ovf);
    if (ovf) begin
      repeat (10) @(negedge clk);
      chk("ovf_no_start", n_starts - s0, 0);
      chk("ovf_idle", busy, 0);
    end else begin
      if (hold_cpu) begin
        repeat (6) begin @(negedge clk); chk("start_held", cpu_start, 0); end
        hold = 1'b0;
      end else begin
        @(negedge clk); chk("start_latency", cpu_start, 1);
      end
      if (wait_done) begin
        for (int k = 0; dq.size() > 0 && k < 500; k++) @(negedge clk);
        chk("done_seen", dq.size(), 0);
        chk("one_start", n_starts - s0, 1);
      end
    end
    chk("writes_drained", wq.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_chk("reset");
    rst = 1'b0;
    p = {8'h15, 8'h2A, 8'h00, 8'h00};
    run_prog(p, 0, 7, 0, 1);
    chk("basic_run_cycles", run_cycles, 7);
    run_prog(p, 5, 7, 0, 1);
    p = {8'h11, 8'h22, 8'h33};
    run_prog(p, 0, 5, 0, 1);
    p = {8'h01, 8'h02, 8'h03, 8'h04};
    run_prog(p, 2, 4, 1, 1);
    run_prog(p, 0, 0, 0, 1);
    chk("timeout_words", words, 0);
    repeat (8) begin
      p = {};
      repeat ($urandom_range(12, 1)) p.push_back(8'($urandom));
      run_prog(p, 3, $urandom_range(30, 1), 0, 1);
    end
    p = {};
    repeat (514) p.push_back(8'($urandom));
    run_prog(p, 0, 5, 0, 1);
    p = {8'hA1, 8'hB2};
    run_prog(p, 1, 3, 0, 1);
    p = {8'h5C, 8'h3D, 8'h7E, 8'h9F};
    run_prog(p, 0, 20, 0, 0);
    for (int k = 0; run_cycles != 16'd3 && k < 100; k++) @(negedge clk);
    chk("reached_run3", run_cycles, 3);
    rst = 1'b1;
    @(negedge clk);
    rst_chk("midrun_reset");
    dq.delete();
    rst = 1'b0;
    for (int k = 0; !cpu_idle && k < 100; k++) @(negedge clk);
    chk("cpu_back_idle", cpu_idle, 1);
    p = {8'hC3, 8'h4B, 8'h12};
    run_prog(p, 2, 6, 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
